// File: rtl/ex_muldiv.sv
// Execute-stage back end: ALU/RV32M result select, iterative divider and EX/MEM register.
// Define EX_MULDIV_RADIX4_DIV_EN to retire two quotient bits per divider cycle.
module ex_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_vld,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_nxt_pc,
  input  logic [4:0]      i_rs1_raddr,
  input  logic [4:0]      i_rs2_raddr,
  input  logic [XLEN-1:0] i_rs1_rdata,
  input  logic [XLEN-1:0] i_rs2_rdata,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic            i_md_en,
  input  logic [2:0]      i_md_op,
  input  logic [2:0]      i_opsel,
  input  logic            i_dmem_ren,
  input  logic            i_dmem_wen,
  input  logic            i_mem_reg,
  input  logic [XLEN-1:0] i_dmem_wdata,
  input  logic [4:0]      i_rd_waddr,
  input  logic            i_rd_wen,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_vld,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_nxt_pc,
  output logic [4:0]      o_rs1_raddr,
  output logic [4:0]      o_rs2_raddr,
  output logic [XLEN-1:0] o_rs1_rdata,
  output logic [XLEN-1:0] o_rs2_rdata,
  output logic [2:0]      o_opsel,
  output logic            o_dmem_ren,
  output logic            o_dmem_wen,
  output logic            o_mem_reg,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [4:0]      o_rd_waddr,
  output logic            o_rd_wen,
  output logic [XLEN-1:0] o_res,
  output logic [XLEN-1:0] o_dmem_addr
);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] nxt_pc;
    logic [4:0]      rs1_raddr;
    logic [4:0]      rs2_raddr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [2:0]      opsel;
    logic            dmem_ren;
    logic            dmem_wen;
    logic            mem_reg;
    logic [XLEN-1:0] dmem_wdata;
    logic [4:0]      rd_waddr;
    logic            rd_wen;
    logic [XLEN-1:0] res;
  } exmem_t;

`ifdef EX_MULDIV_RADIX4_DIV_EN
  localparam logic [4:0] LastCnt = 5'd15;
`else
  localparam logic [4:0] LastCnt = 5'd31;
`endif

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [63:0]     rq_q, rq_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            rem_op_q, rem_op_d;
  exmem_t          exmem_q, exmem_d;
  logic            vld_q;

  logic            a_sgn, b_sgn, div_sgn, div_by_zero, div_ovf, special, start;
  logic [63:0]     a_ext, b_ext, prod;
  logic [XLEN-1:0] rs1_mag, rs2_mag, quo_fix, rem_fix, res;

  // One restoring step; the 33-bit compare keeps the bit shifted out of the remainder.
  function automatic logic [63:0] div_step(input logic [63:0] rq, input logic [31:0] d);
    logic [32:0] diff;
    diff = rq[63:31] - {1'b0, d};
    if (diff[32]) div_step = {rq[62:0], 1'b0};
    else          div_step = {diff[31:0], rq[30:0], 1'b1};
  endfunction

  always_comb begin
    a_sgn       = (i_md_op[1:0] == 2'b01) | (i_md_op[1:0] == 2'b10);
    b_sgn       = (i_md_op[1:0] == 2'b01);
    a_ext       = {{32{a_sgn & i_rs1_rdata[31]}}, i_rs1_rdata};
    b_ext       = {{32{b_sgn & i_rs2_rdata[31]}}, i_rs2_rdata};
    prod        = a_ext * b_ext;
    div_sgn     = ~i_md_op[0];
    div_by_zero = (i_rs2_rdata == '0);
    div_ovf     = div_sgn & (i_rs1_rdata == 32'h8000_0000) & (i_rs2_rdata == 32'hFFFF_FFFF);
    special     = div_by_zero | div_ovf;
    rs1_mag     = (div_sgn & i_rs1_rdata[31]) ? -i_rs1_rdata : i_rs1_rdata;
    rs2_mag     = (div_sgn & i_rs2_rdata[31]) ? -i_rs2_rdata : i_rs2_rdata;
    quo_fix     = neg_quo_q ? -rq_q[31:0] : rq_q[31:0];
    rem_fix     = neg_rem_q ? -rq_q[63:32] : rq_q[63:32];
    start       = (state_q == StIdle) & i_vld & i_md_en & i_md_op[2] & ~special & ~i_flush;
    o_stall     = i_rst_n & (start | (state_q == StDiv));
  end

  always_comb begin
    res = i_alu_res;
    if (state_q == StDone) begin
      res = rem_op_q ? rem_fix : quo_fix;
    end else if (i_md_en) begin
      unique case (i_md_op)
        3'b000:  res = prod[31:0];
        3'b001,
        3'b010,
        3'b011:  res = prod[63:32];
        default: begin
          if (div_by_zero) res = i_md_op[1] ? i_rs1_rdata : 32'hFFFF_FFFF;
          else             res = i_md_op[1] ? 32'h0 : 32'h8000_0000;
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rq_d      = rq_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_op_d  = rem_op_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StDiv;
          cnt_d     = '0;
          rq_d      = {32'h0, rs1_mag};
          dvsr_d    = rs2_mag;
          neg_quo_d = div_sgn & (i_rs1_rdata[31] ^ i_rs2_rdata[31]);
          neg_rem_d = div_sgn & i_rs1_rdata[31];
          rem_op_d  = i_md_op[1];
        end
      end
      StDiv: begin
`ifdef EX_MULDIV_RADIX4_DIV_EN
        rq_d  = div_step(div_step(rq_q, dvsr_q), dvsr_q);
`else
        rq_d  = div_step(rq_q, dvsr_q);
`endif
        cnt_d = cnt_q + 5'd1;
        if (i_flush)               state_d = StIdle;
        else if (cnt_q == LastCnt) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    exmem_d = '{inst: i_inst, pc: i_pc, nxt_pc: i_nxt_pc, rs1_raddr: i_rs1_raddr,
                rs2_raddr: i_rs2_raddr, rs1_rdata: i_rs1_rdata, rs2_rdata: i_rs2_rdata,
                opsel: i_opsel, dmem_ren: i_dmem_ren, dmem_wen: i_dmem_wen,
                mem_reg: i_mem_reg, dmem_wdata: i_dmem_wdata, rd_waddr: i_rd_waddr,
                rd_wen: i_rd_wen, res: res};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rq_q      <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_op_q  <= 1'b0;
      exmem_q   <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rq_q      <= rq_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_op_q  <= rem_op_d;
      vld_q     <= ~o_stall & i_vld & ~i_flush;
      if (!o_stall) exmem_q <= exmem_d;
    end
  end

  assign o_vld        = vld_q;
  assign o_inst       = exmem_q.inst;
  assign o_pc         = exmem_q.pc;
  assign o_nxt_pc     = exmem_q.nxt_pc;
  assign o_rs1_raddr  = exmem_q.rs1_raddr;
  assign o_rs2_raddr  = exmem_q.rs2_raddr;
  assign o_rs1_rdata  = exmem_q.rs1_rdata;
  assign o_rs2_rdata  = exmem_q.rs2_rdata;
  assign o_opsel      = exmem_q.opsel;
  assign o_dmem_ren   = exmem_q.dmem_ren;
  assign o_dmem_wen   = exmem_q.dmem_wen;
  assign o_mem_reg    = exmem_q.mem_reg;
  assign o_dmem_wdata = exmem_q.dmem_wdata;
  assign o_rd_waddr   = exmem_q.rd_waddr;
  assign o_rd_wen     = exmem_q.rd_wen;
  assign o_res        = exmem_q.res;
  assign o_dmem_addr  = exmem_q.res;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table for single ops plus flush and reset sequences.
module tb_ex_muldiv;

`ifdef EX_MULDIV_RADIX4_DIV_EN
  localparam int DivStall = 17;
`else
  localparam int DivStall = 33;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_vld, i_md_en, i_dmem_ren, i_dmem_wen, i_mem_reg, i_rd_wen, i_flush;
  logic [31:0] i_inst, i_pc, i_nxt_pc, i_rs1_rdata, i_rs2_rdata, i_alu_res, i_dmem_wdata;
  logic [4:0]  i_rs1_raddr, i_rs2_raddr, i_rd_waddr;
  logic [2:0]  i_md_op, i_opsel;
  logic        o_stall, o_vld, o_dmem_ren, o_dmem_wen, o_mem_reg, o_rd_wen;
  logic [31:0] o_inst, o_pc, o_nxt_pc, o_rs1_rdata, o_rs2_rdata, o_dmem_wdata, o_res;
  logic [31:0] o_dmem_addr;
  logic [4:0]  o_rs1_raddr, o_rs2_raddr, o_rd_waddr;
  logic [2:0]  o_opsel;

  int total = 0;
  int bad   = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .i_inst(i_inst), .i_pc(i_pc),
    .i_nxt_pc(i_nxt_pc), .i_rs1_raddr(i_rs1_raddr), .i_rs2_raddr(i_rs2_raddr),
    .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata), .i_alu_res(i_alu_res),
    .i_md_en(i_md_en), .i_md_op(i_md_op), .i_opsel(i_opsel), .i_dmem_ren(i_dmem_ren),
    .i_dmem_wen(i_dmem_wen), .i_mem_reg(i_mem_reg), .i_dmem_wdata(i_dmem_wdata),
    .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_flush(i_flush), .o_stall(o_stall),
    .o_vld(o_vld), .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc),
    .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr), .o_rs1_rdata(o_rs1_rdata),
    .o_rs2_rdata(o_rs2_rdata), .o_opsel(o_opsel), .o_dmem_ren(o_dmem_ren),
    .o_dmem_wen(o_dmem_wen), .o_mem_reg(o_mem_reg), .o_dmem_wdata(o_dmem_wdata),
    .o_rd_waddr(o_rd_waddr), .o_rd_wen(o_rd_wen), .o_res(o_res), .o_dmem_addr(o_dmem_addr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        md_en;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] alu;
    logic [31:0] exp;
    int          stalls;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic md_en, input logic [2:0] op, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] alu, input logic [4:0] rd,
                       input logic [31:0] pc);
    i_vld = 1'b1; i_md_en = md_en; i_md_op = op; i_rs1_rdata = rs1; i_rs2_rdata = rs2;
    i_alu_res = alu; i_rd_waddr = rd; i_pc = pc; i_rd_wen = 1'b1;
  endtask

  // Called at a negedge; returns the registered result one edge after stall drops.
  task automatic run(input logic md_en, input logic [2:0] op, input logic [31:0] rs1,
                     input logic [31:0] rs2, input logic [31:0] alu, input logic [4:0] rd,
                     input logic [31:0] pc, output logic [31:0] res, output logic vld,
                     output int stalls, output int vbad);
    drive(md_en, op, rs1, rs2, alu, rd, pc);
    stalls = 0;
    vbad   = 0;
    #1;
    while (o_stall && stalls < 200) begin
      stalls++;
      if (stalls > 1 && o_vld) vbad++;
      @(negedge i_clk);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    res = o_res;
    vld = o_vld;
    i_vld = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic        vld;
    int          stalls, vbad;

    vecs[0]  = '{1'b0, 3'd0, 32'h0000_0003, 32'h0000_0004, 32'h0000_1234, 32'h0000_1234, 0};
    vecs[1]  = '{1'b1, 3'd1, 32'h8000_0000, 32'h0000_0002, 32'h0, 32'hFFFF_FFFF, 0};
    vecs[2]  = '{1'b1, 3'd3, 32'h8000_0000, 32'h0000_0002, 32'h0, 32'h0000_0001, 0};
    vecs[3]  = '{1'b1, 3'd0, 32'h8000_0000, 32'h0000_0002, 32'h0, 32'h0000_0000, 0};
    vecs[4]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 0};
    vecs[5]  = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 0};
    vecs[6]  = '{1'b1, 3'd5, 32'h0000_0055, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 0};
    vecs[7]  = '{1'b1, 3'd7, 32'h0000_0055, 32'h0000_0000, 32'h0, 32'h0000_0055, 0};
    vecs[8]  = '{1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 0};
    vecs[9]  = '{1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0};
    vecs[10] = '{1'b1, 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0, 32'hFFFF_FFFD, DivStall};
    vecs[11] = '{1'b1, 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0, 32'hFFFF_FFFF, DivStall};
    vecs[12] = '{1'b1, 3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFD, DivStall};
    vecs[13] = '{1'b1, 3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0, 32'h0000_0001, DivStall};
    vecs[14] = '{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0, 32'h0000_0001, DivStall};
    vecs[15] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0, 32'h7FFF_FFFE, DivStall};

    i_rst_n = 1'b0; i_vld = 1'b0; i_md_en = 1'b0; i_md_op = '0; i_flush = 1'b0;
    i_inst = 32'h0000_0033; i_pc = '0; i_nxt_pc = '0; i_rs1_raddr = 5'd1; i_rs2_raddr = 5'd2;
    i_rs1_rdata = '0; i_rs2_rdata = '0; i_alu_res = '0; i_opsel = '0; i_dmem_ren = 1'b0;
    i_dmem_wen = 1'b0; i_mem_reg = 1'b0; i_dmem_wdata = '0; i_rd_waddr = '0; i_rd_wen = 1'b0;
    #1;
    check("reset_vld", {31'b0, o_vld}, 32'h0);
    check("reset_stall", {31'b0, o_stall}, 32'h0);
    check("reset_res", o_res, 32'h0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 16; i++) begin
      run(vecs[i].md_en, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].alu, 5'(i + 5),
          32'h1000 + 32'(i * 4), res, vld, stalls, vbad);
      check($sformatf("v%0d_res", i), res, vecs[i].exp);
      check($sformatf("v%0d_stalls", i), 32'(stalls), 32'(vecs[i].stalls));
      check($sformatf("v%0d_vld", i), {31'b0, vld}, 32'h1);
      check($sformatf("v%0d_bubbles", i), 32'(vbad), 32'h0);
      check($sformatf("v%0d_addr", i), o_dmem_addr, vecs[i].exp);
      check($sformatf("v%0d_rd", i), {27'b0, o_rd_waddr}, 32'(i + 5));
      check($sformatf("v%0d_pc", i), o_pc, 32'h1000 + 32'(i * 4));
    end

    // Flush in the middle of a divide, then an ALU op must pass normally.
    drive(1'b1, 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0, 5'd9, 32'h2000);
    repeat (10) @(negedge i_clk);
    i_flush = 1'b1;
    #1;
    check("flush_stall_hold", {31'b0, o_stall}, 32'h1);
    @(negedge i_clk);
    i_flush = 1'b0; i_md_en = 1'b0; i_alu_res = 32'h0000_0077; i_rd_waddr = 5'd10;
    #1;
    check("flush_stall_drop", {31'b0, o_stall}, 32'h0);
    check("flush_vld", {31'b0, o_vld}, 32'h0);
    @(negedge i_clk);
    check("flush_add_res", o_res, 32'h0000_0077);
    check("flush_add_vld", {31'b0, o_vld}, 32'h1);
    i_vld = 1'b0;
    @(negedge i_clk);

    // Asynchronous reset mid-divide, then a fresh divide.
    drive(1'b1, 3'd5, 32'd100, 32'd7, 32'h0, 5'd11, 32'h3000);
    repeat (5) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_mid_stall", {31'b0, o_stall}, 32'h0);
    check("rst_mid_vld", {31'b0, o_vld}, 32'h0);
    check("rst_mid_res", o_res, 32'h0);
    check("rst_mid_rd", {27'b0, o_rd_waddr}, 32'h0);
    i_vld = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    run(1'b1, 3'd5, 32'd100, 32'd7, 32'h0, 5'd12, 32'h3004, res, vld, stalls, vbad);
    check("post_rst_divu", res, 32'd14);
    check("post_rst_stalls", 32'(stalls), 32'(DivStall));
    check("post_rst_vld", {31'b0, vld}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
